pipelined_adder_tree: RTL and testbench

//  Sums N_IN signed operands (e.g. 9 products of a 3x3 conv window) through a registered binary tree.

---
 rtl/pipelined_adder_tree_pkg.sv | 9 +
 rtl/pipelined_adder_tree_level.sv | 36 +++
 rtl/pipelined_adder_tree.sv | 114 +++++++++++
 tb/tb_pipelined_adder_tree.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree: tree depth calculation.
package pipelined_adder_tree_pkg;

    // Number of registered levels; a single operand still gets one stage.
    function automatic int unsigned tree_levels(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipelined_adder_tree_level.sv
// One registered level of the adder tree: N_PAIRS signed adds, each growing by one bit.
module adder_tree_level
    import pipelined_adder_tree_pkg::*;
#(
    parameter int unsigned N_PAIRS = 1,
    parameter int unsigned W       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_en,
    input  logic [2*N_PAIRS*W-1:0]     i_data,
    output logic [N_PAIRS*(W+1)-1:0]   o_data
);

    logic [N_PAIRS*(W+1)-1:0] r_sum;
    logic [N_PAIRS*(W+1)-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int p = 0; p < int'(N_PAIRS); p++) begin
            w_sum[p*(W+1) +: W+1] = (W+1)'($signed(i_data[(2*p)*W +: W]))
                                  + (W+1)'($signed(i_data[(2*p+1)*W +: W]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (i_en) begin
            r_sum <= w_sum;
        end
    end

    assign o_data = r_sum;

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined signed adder tree with valid/ready flow control and a global stall.
// Optional result accumulator across vector groups: define ADDER_TREE_ACC_EN.
module pipelined_adder_tree
    import pipelined_adder_tree_pkg::*;
#(
    parameter int unsigned N_IN  = 9,
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 20,
    parameter int unsigned ACC_W = 24
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_IN*IN_W-1:0]     in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     acc_last,
`ifdef ADDER_TREE_ACC_EN
    output logic signed [ACC_W-1:0]  out_sum,
`else
    output logic signed [OUT_W-1:0]  out_sum,
`endif
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int unsigned LEVELS = tree_levels(N_IN);
    localparam int unsigned P2     = 1 << LEVELS;
    localparam int unsigned TREE_W = IN_W + LEVELS;

    logic                     w_adv;
    logic [LEVELS-1:0]        r_vld;
    logic [P2*IN_W-1:0]       w_pad;
    logic signed [TREE_W-1:0] w_tree;

    // Unused upper operand slots are zero so they do not disturb the sum.
    assign w_pad    = (P2*IN_W)'(in_data);
    assign in_ready = w_adv;

    for (genvar k = 1; k <= int'(LEVELS); k++) begin : g_lvl
        localparam int unsigned NP = P2 >> k;
        localparam int unsigned LW = IN_W + k - 1;

        logic [2*NP*LW-1:0]   w_in;
        logic [NP*(LW+1)-1:0] w_out;

        if (k == 1) begin : g_first
            assign w_in = w_pad;
        end else begin : g_next
            assign w_in = g_lvl[k-1].w_out;
        end

        adder_tree_level #(
            .N_PAIRS (NP),
            .W       (LW)
        ) u_level (
            .clk    (clk),
            .rst_n  (rstn),
            .i_en   (w_adv),
            .i_data (w_in),
            .o_data (w_out)
        );
    end

    assign w_tree = g_lvl[LEVELS].w_out;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= '0;
        end else if (w_adv) begin
            r_vld <= LEVELS'({r_vld, in_valid});
        end
    end

`ifdef ADDER_TREE_ACC_EN
    logic [LEVELS-1:0]       r_last;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_out_sum;
    logic signed [ACC_W-1:0] w_acc_sum;
    logic                    r_out_valid;

    assign w_adv     = !r_out_valid || out_ready;
    assign w_acc_sum = r_acc + ACC_W'(w_tree);

    // Accumulate each valid tree result; emit and clear on the group's last one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last      <= '0;
            r_acc       <= '0;
            r_out_sum   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_last      <= LEVELS'({r_last, in_valid && acc_last});
            r_out_valid <= 1'b0;
            if (r_vld[LEVELS-1]) begin
                if (r_last[LEVELS-1]) begin
                    r_out_sum   <= w_acc_sum;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                end else begin
                    r_acc <= w_acc_sum;
                end
            end
        end
    end

    assign out_sum   = r_out_sum;
    assign out_valid = r_out_valid;
`else
    assign w_adv     = !r_vld[LEVELS-1] || out_ready;
    assign out_sum   = OUT_W'(w_tree);
    assign out_valid = r_vld[LEVELS-1];
`endif

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Scoreboard bench for pipelined_adder_tree (default build or ADDER_TREE_ACC_EN).
module tb_pipelined_adder_tree;
    import pipelined_adder_tree_pkg::*;

    localparam int unsigned N_IN   = 9;
    localparam int unsigned IN_W   = 16;
    localparam int unsigned OUT_W  = 20;
    localparam int unsigned ACC_W  = 24;
    localparam int unsigned LEVELS = tree_levels(N_IN);
`ifdef ADDER_TREE_ACC_EN
    localparam int unsigned SW  = ACC_W;
    localparam int unsigned LAT = LEVELS + 1;
    localparam bit          ACC = 1'b1;
`else
    localparam int unsigned SW  = OUT_W;
    localparam int unsigned LAT = LEVELS;
    localparam bit          ACC = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic [N_IN*IN_W-1:0]   in_data = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic                   acc_last = 1'b1;
    logic signed [SW-1:0]   out_sum;
    logic                   out_valid;
    logic                   out_ready = 1'b1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_out = 0;
    logic signed [SW-1:0] sb_q[$];
    longint               m_acc = 0;
    bit                   hold_chk = 1'b0;
    logic signed [SW-1:0] held;

    pipelined_adder_tree #(
        .N_IN (N_IN), .IN_W (IN_W), .OUT_W (OUT_W), .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_last  (acc_last),
        .out_sum   (out_sum),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic longint vsum(input logic [N_IN*IN_W-1:0] v);
        longint s = 0;
        for (int i = 0; i < int'(N_IN); i++) s += longint'($signed(v[i*IN_W +: IN_W]));
        return s;
    endfunction

    function automatic logic [N_IN*IN_W-1:0] rand_vec();
        logic [N_IN*IN_W-1:0] v;
        for (int i = 0; i < int'(N_IN); i++) v[i*IN_W +: IN_W] = IN_W'($urandom);
        return v;
    endfunction

    // Monitor: capture accepted inputs into the model, check outputs and stall stability.
    always @(negedge clk) begin
        logic signed [SW-1:0] exp_v;
        cyc++;
        if (rstn) begin
            if (hold_chk) begin
                total++;
                if (!out_valid || out_sum !== held) begin
                    bad++;
                    $display("FAIL stall_hold: valid=%0b sum=%0d required held %0d", out_valid, out_sum, held);
                end
            end
            hold_chk = out_valid && !out_ready;
            held     = out_sum;
            if (in_valid && in_ready) begin
                m_acc += vsum(in_data);
                if (!ACC || acc_last) begin
                    sb_q.push_back(SW'(m_acc));
                    m_acc = 0;
                end
            end
            if (out_valid && out_ready) begin
                total++;
                n_out++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got sum=%0d with empty scoreboard", out_sum);
                end else begin
                    exp_v = sb_q.pop_front();
                    if (out_sum !== exp_v) begin
                        bad++;
                        $display("FAIL sb_sum: got %0d required %0d", out_sum, exp_v);
                    end
                end
            end
        end else begin
            hold_chk = 1'b0;
        end
    end

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || out_sum !== SW'(0) || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: valid=%0b sum=%0d ready=%0b required 0/0/1", out_valid, out_sum, in_ready);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [N_IN*IN_W-1:0] v;
        int n;
        for (int i = 0; i < int'(N_IN); i++) v[i*IN_W +: IN_W] = IN_W'(1);
        out_ready = 1'b1;
        acc_last  = 1'b1;
        in_data   = v;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n != int'(LAT)) begin
            bad++;
            $display("FAIL single_latency: got %0d cycles required %0d", n, LAT);
        end
        total++;
        if (out_sum !== SW'(9)) begin
            bad++;
            $display("FAIL single_sum: got %0d required 9", out_sum);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_extremes();
        logic signed [IN_W-1:0] opv[2];
        int                     expv[2];
        int                     n;
        opv  = '{-16'sd32768, 16'sd32767};
        expv = '{-294912, 294903};
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < int'(N_IN); i++) in_data[i*IN_W +: IN_W] = opv[t];
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            total++;
            if (out_sum !== SW'(expv[t])) begin
                bad++;
                $display("FAIL extreme_%0d: got %0d required %0d", t, out_sum, expv[t]);
            end
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int n0, c0, g;
        n0 = n_out;
        c0 = cyc;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data  = rand_vec();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        g = 0;
        while (sb_q.size() != 0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        total++;
        if (n_out - n0 != 20 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_count: got %0d outputs, %0d pending, required 20/0", n_out - n0, sb_q.size());
        end
        total++;
        if (cyc - c0 > 20 + int'(LAT) + 2) begin
            bad++;
            $display("FAIL b2b_throughput: took %0d cycles required <= %0d", cyc - c0, 20 + LAT + 2);
        end
    endtask

    task automatic test_random_stall();
        int  n0, guard, g;
        bit  acc_ok;
        n0 = n_out;
        for (int i = 0; i < 40; i++) begin
            in_data  = rand_vec();
            in_valid = 1'b1;
            guard    = 0;
            do begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                acc_ok = in_ready;
                @(posedge clk); #1;
                guard++;
            end while (!acc_ok && guard < 1000);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        g = 0;
        while (sb_q.size() != 0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        total++;
        if (n_out - n0 != 40 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL stall_count: got %0d outputs, %0d pending, required 40/0", n_out - n0, sb_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int n0, g;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data  = rand_vec();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n0 = n_out;
        rstn = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_valid: got %0b required 0", out_valid);
        end
        sb_q.delete();
        m_acc = 0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        in_data  = rand_vec();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        g = 0;
        while (sb_q.size() != 0 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (n_out - n0 != 1 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL midreset_out: got %0d outputs, %0d pending, required 1/0", n_out - n0, sb_q.size());
        end
    endtask

`ifdef ADDER_TREE_ACC_EN
    task automatic test_acc();
        int vals[4][2];
        bit lasts[4];
        int n0, n;
        vals  = '{'{10, 0}, '{3, -7}, '{7, 0}, '{5, 0}};
        lasts = '{1'b0, 1'b0, 1'b1, 1'b1};
        n0 = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = '0;
            in_data[0 +: IN_W]    = IN_W'(vals[i][0]);
            in_data[IN_W +: IN_W] = IN_W'(vals[i][1]);
            acc_last = lasts[i];
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        acc_last = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (out_sum !== SW'(13)) begin
            bad++;
            $display("FAIL acc_group1: got %0d required 13", out_sum);
        end
        @(posedge clk); #1;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (out_sum !== SW'(5)) begin
            bad++;
            $display("FAIL acc_group2: got %0d required 5", out_sum);
        end
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (n_out - n0 != 2) begin
            bad++;
            $display("FAIL acc_count: got %0d outputs required 2", n_out - n0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_back_to_back();
        test_random_stall();
        test_reset_midflight();
`ifdef ADDER_TREE_ACC_EN
        test_acc();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
